// File: rtl/bp_trigger_ctrl.sv
// Trigger CSR controller for a two-entry breakpoint unit; optional BP_RANGE_EN enables range match on trigger 1.
// Latency: request accepted in T, state committed end of T+1, response valid from T+2.
// Backpressure: one access in flight; ready stays low until the response is taken.
module bp_trigger_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_csr_req_valid,
    output logic        io_csr_req_ready,
    input  logic        io_csr_req_wen,
    input  logic [11:0] io_csr_req_addr,
    input  logic [31:0] io_csr_req_wdata,
    output logic        io_csr_resp_valid,
    input  logic        io_csr_resp_ready,
    output logic [31:0] io_csr_resp_rdata,
    output logic        io_csr_resp_illegal,
    input  logic        io_status_debug,
    output logic [31:0] io_bp_0_control,
    output logic [31:0] io_bp_1_control,
    output logic [31:0] io_bp_0_address,
    output logic [31:0] io_bp_1_address,
    input  logic        io_xcpt_if,
    input  logic        io_xcpt_ld,
    input  logic        io_xcpt_st,
    input  logic        io_hit_clear,
    output logic        io_hit_pending,
    output logic [2:0]  io_hit_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [31:0] CTRL_RST     = 32'h2000_0000;

    state_t      state_q, state_d;
    logic        req_wen_q, req_wen_d;
    logic [11:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        tselect_q, tselect_d;
    logic [31:0] ctrl0_q, ctrl0_d, ctrl1_q, ctrl1_d;
    logic [31:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;
    logic [2:0]  cause_q, cause_d;

    logic [31:0] sel_ctrl, sel_addr, new_ctrl;
    logic        locked;

    // Hardwired fields are regenerated; unsupported bpmatch encodings collapse to exact match.
    function automatic logic [31:0] legalise(input logic [31:0] wdata, input logic sel);
        logic [3:0] bpmatch;
        logic       ok;
        bpmatch = wdata[10:7];
        ok      = (bpmatch == 4'd0) || (bpmatch == 4'd2);
`ifdef BP_RANGE_EN
        ok      = ok || (sel && (bpmatch == 4'd1));
`else
        ok      = ok && (sel || !sel);
`endif
        return {4'h2, 5'd0, 4'd0, wdata[18:11], (ok ? bpmatch : 4'd0), wdata[6:0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        req_wen_d   = req_wen_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        tselect_d   = tselect_q;
        ctrl0_d     = ctrl0_q;
        ctrl1_d     = ctrl1_q;
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        rdata_d     = rdata_q;
        illegal_d   = illegal_q;
        new_ctrl    = 32'd0;
        sel_ctrl    = tselect_q ? ctrl1_q : ctrl0_q;
        sel_addr    = tselect_q ? addr1_q : addr0_q;
        // A debug-owned trigger may only be reprogrammed from debug mode.
        locked      = sel_ctrl[11] && !io_status_debug;

        case (state_q)
            S_IDLE: begin
                if (io_csr_req_valid) begin
                    req_wen_d   = io_csr_req_wen;
                    req_addr_d  = io_csr_req_addr;
                    req_wdata_d = io_csr_req_wdata;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d   = S_RESP;
                illegal_d = 1'b0;
                case (req_addr_q)
                    ADDR_TSELECT: begin
                        if (req_wen_q && (req_wdata_q[31:1] == 31'd0)) begin
                            tselect_d = req_wdata_q[0];
                        end
                        rdata_d = {31'd0, tselect_d};
                    end
                    ADDR_TDATA1: begin
                        if (req_wen_q && locked) begin
                            illegal_d = 1'b1;
                            rdata_d   = sel_ctrl;
                        end else if (req_wen_q) begin
                            new_ctrl = legalise(req_wdata_q, tselect_q);
                            if (tselect_q) ctrl1_d = new_ctrl;
                            else           ctrl0_d = new_ctrl;
                            rdata_d = new_ctrl;
                        end else begin
                            rdata_d = sel_ctrl;
                        end
                    end
                    ADDR_TDATA2: begin
                        if (req_wen_q && locked) begin
                            illegal_d = 1'b1;
                            rdata_d   = sel_addr;
                        end else if (req_wen_q) begin
                            if (tselect_q) addr1_d = req_wdata_q;
                            else           addr0_d = req_wdata_q;
                            rdata_d = req_wdata_q;
                        end else begin
                            rdata_d = sel_addr;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        rdata_d   = 32'd0;
                    end
                endcase
            end
            S_RESP: begin
                if (io_csr_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A hit arriving alongside clear survives it.
        cause_d = (io_hit_clear ? 3'b000 : cause_q) | {io_xcpt_st, io_xcpt_ld, io_xcpt_if};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_wen_q   <= 1'b0;
            req_addr_q  <= 12'd0;
            req_wdata_q <= 32'd0;
            tselect_q   <= 1'b0;
            ctrl0_q     <= CTRL_RST;
            ctrl1_q     <= CTRL_RST;
            addr0_q     <= 32'd0;
            addr1_q     <= 32'd0;
            rdata_q     <= 32'd0;
            illegal_q   <= 1'b0;
            cause_q     <= 3'b000;
        end else begin
            state_q     <= state_d;
            req_wen_q   <= req_wen_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            tselect_q   <= tselect_d;
            ctrl0_q     <= ctrl0_d;
            ctrl1_q     <= ctrl1_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            rdata_q     <= rdata_d;
            illegal_q   <= illegal_d;
            cause_q     <= cause_d;
        end
    end

    assign io_csr_req_ready    = (state_q == S_IDLE);
    assign io_csr_resp_valid   = (state_q == S_RESP);
    assign io_csr_resp_rdata   = rdata_q;
    assign io_csr_resp_illegal = illegal_q;
    assign io_bp_0_control     = ctrl0_q;
    assign io_bp_1_control     = ctrl1_q;
    assign io_bp_0_address     = addr0_q;
    assign io_bp_1_address     = addr1_q;
    assign io_hit_cause        = cause_q;
    assign io_hit_pending      = |cause_q;

endmodule

// File: tb/tb_bp_trigger_ctrl.sv
// Scoreboard bench for bp_trigger_ctrl: directed CSR accesses push expected responses, a monitor pops on handshake.
module tb_bp_trigger_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_csr_req_valid = 1'b0;
    logic        io_csr_req_ready;
    logic        io_csr_req_wen = 1'b0;
    logic [11:0] io_csr_req_addr = 12'd0;
    logic [31:0] io_csr_req_wdata = 32'd0;
    logic        io_csr_resp_valid;
    logic        io_csr_resp_ready = 1'b1;
    logic [31:0] io_csr_resp_rdata;
    logic        io_csr_resp_illegal;
    logic        io_status_debug = 1'b0;
    logic [31:0] io_bp_0_control, io_bp_1_control, io_bp_0_address, io_bp_1_address;
    logic        io_xcpt_if = 1'b0, io_xcpt_ld = 1'b0, io_xcpt_st = 1'b0;
    logic        io_hit_clear = 1'b0;
    logic        io_hit_pending;
    logic [2:0]  io_hit_cause;

    bp_trigger_ctrl dut (
        .clk(clk), .reset(reset),
        .io_csr_req_valid(io_csr_req_valid), .io_csr_req_ready(io_csr_req_ready),
        .io_csr_req_wen(io_csr_req_wen), .io_csr_req_addr(io_csr_req_addr),
        .io_csr_req_wdata(io_csr_req_wdata),
        .io_csr_resp_valid(io_csr_resp_valid), .io_csr_resp_ready(io_csr_resp_ready),
        .io_csr_resp_rdata(io_csr_resp_rdata), .io_csr_resp_illegal(io_csr_resp_illegal),
        .io_status_debug(io_status_debug),
        .io_bp_0_control(io_bp_0_control), .io_bp_1_control(io_bp_1_control),
        .io_bp_0_address(io_bp_0_address), .io_bp_1_address(io_bp_1_address),
        .io_xcpt_if(io_xcpt_if), .io_xcpt_ld(io_xcpt_ld), .io_xcpt_st(io_xcpt_st),
        .io_hit_clear(io_hit_clear), .io_hit_pending(io_hit_pending), .io_hit_cause(io_hit_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

`ifdef BP_RANGE_EN
    localparam logic [31:0] EXP_RANGE = 32'h2000_0080;
`else
    localparam logic [31:0] EXP_RANGE = 32'h2000_0000;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!reset && io_csr_resp_valid && io_csr_resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_illegal", {31'd0, io_csr_resp_illegal}, {31'd0, e.illegal});
                if (e.chk_rdata) chk("resp_rdata", io_csr_resp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic wen, input logic [11:0] addr, input logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        io_csr_req_valid = 1'b1;
        io_csr_req_wen   = wen;
        io_csr_req_addr  = addr;
        io_csr_req_wdata = wdata;
        while (!io_csr_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {31'd0, io_csr_req_ready}, 32'd1);
        @(posedge clk);
        #1 io_csr_req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic access(input logic wen, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic illegal, input logic chk_rd);
        exp_t e;
        e.rdata = rdata; e.illegal = illegal; e.chk_rdata = chk_rd;
        sb.push_back(e);
        issue(wen, addr, wdata);
        wait_resp();
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, io_csr_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, io_csr_resp_valid}, 32'd0);
        chk("rst_rdata", io_csr_resp_rdata, 32'd0);
        chk("rst_ctrl0", io_bp_0_control, 32'h2000_0000);
        chk("rst_ctrl1", io_bp_1_control, 32'h2000_0000);
        chk("rst_addr0", io_bp_0_address, 32'd0);
        chk("rst_cause", {28'd0, io_hit_pending, io_hit_cause}, 32'd0);

        // First read with timing checks
        e.rdata = 32'h2000_0000; e.illegal = 1'b0; e.chk_rdata = 1'b1;
        sb.push_back(e);
        issue(1'b0, 12'h7A1, 32'd0);
        @(negedge clk);
        chk("t1_ready", {31'd0, io_csr_req_ready}, 32'd0);
        chk("t1_resp_valid", {31'd0, io_csr_resp_valid}, 32'd0);
        @(negedge clk);
        chk("t2_ready", {31'd0, io_csr_req_ready}, 32'd0);
        chk("t2_resp_valid", {31'd0, io_csr_resp_valid}, 32'd1);
        wait_resp();

        // Trigger 1 legalisation
        io_status_debug = 1'b1;
        access(1'b1, 12'h7A0, 32'd1, 32'd1, 1'b0, 1'b1);
        e.rdata = 32'h2007_F87F; e.illegal = 1'b0; e.chk_rdata = 1'b1;
        sb.push_back(e);
        issue(1'b1, 12'h7A1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ctrl1_before_commit", io_bp_1_control, 32'h2000_0000);
        @(negedge clk);
        chk("ctrl1_after_commit", io_bp_1_control, 32'h2007_F87F);
        wait_resp();
        access(1'b0, 12'h7A1, 32'd0, 32'h2007_F87F, 1'b0, 1'b1);
        access(1'b1, 12'h7A1, 32'h0000_0080, EXP_RANGE, 1'b0, 1'b1);
        access(1'b1, 12'h7A1, 32'h0000_0100, 32'h2000_0100, 1'b0, 1'b1);
        access(1'b1, 12'h7A1, 32'h0000_0000, 32'h2000_0000, 1'b0, 1'b1);

        // Trigger 0 bpmatch=3 dropped, dmode lock
        access(1'b1, 12'h7A0, 32'd0, 32'd0, 1'b0, 1'b1);
        access(1'b1, 12'h7A1, 32'h0000_0980, 32'h2000_0800, 1'b0, 1'b1);
        access(1'b1, 12'h7A2, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        io_status_debug = 1'b0;
        access(1'b1, 12'h7A2, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        chk("locked_addr0", io_bp_0_address, 32'h1234_5678);
        access(1'b1, 12'h7A1, 32'h0000_0000, 32'd0, 1'b1, 1'b0);
        chk("locked_ctrl0", io_bp_0_control, 32'h2000_0800);
        access(1'b0, 12'h7A1, 32'd0, 32'h2000_0800, 1'b0, 1'b1);
        access(1'b0, 12'h7A2, 32'd0, 32'h1234_5678, 1'b0, 1'b1);

        // tselect out of range, bad address
        access(1'b1, 12'h7A0, 32'd1, 32'd1, 1'b0, 1'b1);
        access(1'b1, 12'h7A0, 32'd5, 32'd1, 1'b0, 1'b1);
        access(1'b0, 12'h7A0, 32'd0, 32'd1, 1'b0, 1'b1);
        access(1'b0, 12'h7A3, 32'd0, 32'd0, 1'b1, 1'b1);
        access(1'b1, 12'h7A3, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);

        // Hit record
        @(negedge clk);
        io_xcpt_ld = 1'b1;
        @(negedge clk);
        io_xcpt_ld = 1'b0;
        chk("hit_ld", {28'd0, io_hit_pending, io_hit_cause}, {28'd0, 1'b1, 3'b010});
        io_xcpt_if = 1'b1;
        io_hit_clear = 1'b1;
        @(negedge clk);
        io_xcpt_if = 1'b0;
        chk("hit_if_clear", {28'd0, io_hit_pending, io_hit_cause}, {28'd0, 1'b1, 3'b001});
        @(negedge clk);
        io_hit_clear = 1'b0;
        chk("hit_cleared", {28'd0, io_hit_pending, io_hit_cause}, 32'd0);

        // Response stall with a competing request
        io_csr_resp_ready = 1'b0;
        e.rdata = 32'd1; e.illegal = 1'b0; e.chk_rdata = 1'b1;
        sb.push_back(e);
        issue(1'b0, 12'h7A0, 32'd0);
        io_csr_req_valid = 1'b1;
        io_csr_req_wen   = 1'b1;
        io_csr_req_addr  = 12'h7A0;
        io_csr_req_wdata = 32'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", {31'd0, io_csr_resp_valid}, 32'd1);
            chk("stall_rdata", io_csr_resp_rdata, 32'd1);
            chk("stall_ready", {31'd0, io_csr_req_ready}, 32'd0);
            @(negedge clk);
        end
        io_csr_req_valid = 1'b0;
        io_csr_resp_ready = 1'b1;
        wait_resp();

        // Reset during EXEC aborts a write
        issue(1'b1, 12'h7A2, 32'hDEAD_BEEF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_addr1", io_bp_1_address, 32'd0);
        chk("abort_resp_valid", {31'd0, io_csr_resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_resp", {31'd0, io_csr_resp_valid}, 32'd0);
        chk("abort_ready", {31'd0, io_csr_req_ready}, 32'd1);
        chk("abort_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
